usb_cdc_input_conditioner: RTL and testbench

//  Parametrised front end for the device_inputs pins of usb_cdc_devices.
//  Per channel: synchronises asynchronous pad inputs, debounces them, emits

---
 rtl/usb_cdc_input_conditioner.sv | 105 ++++++++++
 tb/tb_usb_cdc_input_conditioner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/usb_cdc_input_conditioner.sv
// Per-channel pad input conditioner: synchroniser, debounce filter, edge pulses
// and sticky pending flags with an ack mask, feeding the CDC device core.
module usb_cdc_input_conditioner #(
  parameter int N_IN            = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic [N_IN-1:0] raw_i,
  input  logic [N_IN-1:0] ack_i,
  output logic [N_IN-1:0] level_o,
  output logic [N_IN-1:0] rise_o,
  output logic [N_IN-1:0] fall_o,
  output logic [N_IN-1:0] pend_o,
  output logic            changed_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]  r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [N_IN];
  logic [N_IN-1:0]  r_level;
  logic [N_IN-1:0]  r_rise;
  logic [N_IN-1:0]  r_fall;
  logic [N_IN-1:0]  r_pend;
  logic             r_changed;

  logic [N_IN-1:0]  w_s;
  logic [CNT_W-1:0] w_cnt_nxt [N_IN];
  logic [N_IN-1:0]  w_level_nxt;
  logic [N_IN-1:0]  w_rise;
  logic [N_IN-1:0]  w_fall;
  logic [N_IN-1:0]  w_src;
  logic [N_IN-1:0]  w_pend_nxt;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    w_level_nxt = r_level;
    w_rise      = '0;
    w_fall      = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_s[i] == r_level[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_cnt_nxt[i]   = '0;
        w_level_nxt[i] = w_s[i];
        w_rise[i]      = w_s[i];
        w_fall[i]      = ~w_s[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    case (EDGE_MODE)
      1:       w_src = w_rise;
      2:       w_src = w_fall;
      default: w_src = w_rise | w_fall;
    endcase
  end

  // Pending bits set on the same edge the pulse is registered; set beats ack.
  assign w_pend_nxt = (r_pend & ~ack_i) | w_src;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < N_IN; i++) r_cnt[i] <= '0;
      r_level   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_pend    <= '0;
      r_changed <= 1'b0;
    end else begin
      for (int i = 0; i < N_IN; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_level   <= w_level_nxt;
      r_rise    <= w_rise;
      r_fall    <= w_fall;
      r_pend    <= w_pend_nxt;
      r_changed <= |w_pend_nxt;
    end
  end

  assign level_o   = r_level;
  assign rise_o    = r_rise;
  assign fall_o    = r_fall;
  assign pend_o    = r_pend;
  assign changed_o = r_changed;

endmodule

// File: tb/tb_usb_cdc_input_conditioner.sv
// Directed bench for usb_cdc_input_conditioner: both-edge instance driven from a
// vector table, plus a falling-edge-only instance exercised by hand.
module tb_usb_cdc_input_conditioner;

  logic       clk;
  logic       rst;
  logic [7:0] raw, ack;
  logic [7:0] level, rise, fall, pend;
  logic       chg;

  logic [7:0] raw1, ack1;
  logic [7:0] level1, rise1, fall1, pend1;
  logic       chg1;

  int checks   = 0;
  int failures = 0;
  int rise5_cnt = 0;
  int fall5_cnt = 0;

  usb_cdc_input_conditioner #(.N_IN(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .EDGE_MODE(0)) dut0 (
    .clk(clk), .rst_i(rst), .raw_i(raw), .ack_i(ack),
    .level_o(level), .rise_o(rise), .fall_o(fall), .pend_o(pend), .changed_o(chg)
  );

  usb_cdc_input_conditioner #(.N_IN(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .EDGE_MODE(2)) dut1 (
    .clk(clk), .rst_i(rst), .raw_i(raw1), .ack_i(ack1),
    .level_o(level1), .rise_o(rise1), .fall_o(fall1), .pend_o(pend1), .changed_o(chg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] raw;
    logic [7:0] ack;
    int         steps;
    logic [7:0] level;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] pend;
    logic       chg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [7:0] rw, logic [7:0] ak, int n,
                              logic [7:0] lv, logic [7:0] rs, logic [7:0] fl,
                              logic [7:0] pd, logic ch);
    vec_t v;
    v.rst = r; v.raw = rw; v.ack = ak; v.steps = n;
    v.level = lv; v.rise = rs; v.fall = fl; v.pend = pd; v.chg = ch;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 ns after each edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rise1[5]) rise5_cnt++;
      if (fall1[5]) fall5_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; raw = 8'h00; ack = 8'h00; raw1 = 8'h00; ack1 = 8'h00;

    // reset with all pads high, then release
    tbl.push_back(mk(1, 8'hFF, 8'h00,  1, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 8'hFF, 8'h00,  2, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'hFF, 8'h00,  1, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'hFF, 8'h00, 16, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'hFF, 8'h00,  1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 1));
    tbl.push_back(mk(0, 8'hFF, 8'h00,  1, 8'hFF, 8'h00, 8'h00, 8'hFF, 1));
    // re-reset with pads low
    tbl.push_back(mk(1, 8'h00, 8'h00,  1, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00,  1, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    // ch0 rise after 18 edges, single-cycle pulse
    tbl.push_back(mk(0, 8'h01, 8'h00, 17, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h01, 8'h00,  1, 8'h01, 8'h01, 8'h00, 8'h01, 1));
    tbl.push_back(mk(0, 8'h01, 8'h00,  1, 8'h01, 8'h00, 8'h00, 8'h01, 1));
    tbl.push_back(mk(0, 8'h01, 8'h00,  5, 8'h01, 8'h00, 8'h00, 8'h01, 1));
    // ch3 high for 15 cycles is rejected, 16+ is accepted
    tbl.push_back(mk(0, 8'h09, 8'h00, 15, 8'h01, 8'h00, 8'h00, 8'h01, 1));
    tbl.push_back(mk(0, 8'h01, 8'h00,  5, 8'h01, 8'h00, 8'h00, 8'h01, 1));
    tbl.push_back(mk(0, 8'h01, 8'h00, 10, 8'h01, 8'h00, 8'h00, 8'h01, 1));
    tbl.push_back(mk(0, 8'h09, 8'h00, 17, 8'h01, 8'h00, 8'h00, 8'h01, 1));
    tbl.push_back(mk(0, 8'h09, 8'h00,  1, 8'h09, 8'h08, 8'h00, 8'h09, 1));
    tbl.push_back(mk(0, 8'h09, 8'h00,  1, 8'h09, 8'h00, 8'h00, 8'h09, 1));
    // build pend=05, then ack ch0
    tbl.push_back(mk(0, 8'h09, 8'h08,  1, 8'h09, 8'h00, 8'h00, 8'h01, 1));
    tbl.push_back(mk(0, 8'h0D, 8'h00, 17, 8'h09, 8'h00, 8'h00, 8'h01, 1));
    tbl.push_back(mk(0, 8'h0D, 8'h00,  1, 8'h0D, 8'h04, 8'h00, 8'h05, 1));
    tbl.push_back(mk(0, 8'h0D, 8'h00,  1, 8'h0D, 8'h00, 8'h00, 8'h05, 1));
    tbl.push_back(mk(0, 8'h0D, 8'h01,  1, 8'h0D, 8'h00, 8'h00, 8'h04, 1));
    tbl.push_back(mk(0, 8'h0D, 8'h00,  1, 8'h0D, 8'h00, 8'h00, 8'h04, 1));
    // ch2 falls then rises again with ack on the accepting edge: set wins
    tbl.push_back(mk(0, 8'h09, 8'h00, 17, 8'h0D, 8'h00, 8'h00, 8'h04, 1));
    tbl.push_back(mk(0, 8'h09, 8'h00,  1, 8'h09, 8'h00, 8'h04, 8'h04, 1));
    tbl.push_back(mk(0, 8'h0D, 8'h00, 17, 8'h09, 8'h00, 8'h00, 8'h04, 1));
    tbl.push_back(mk(0, 8'h0D, 8'h04,  1, 8'h0D, 8'h04, 8'h00, 8'h04, 1));
    tbl.push_back(mk(0, 8'h0D, 8'h00,  1, 8'h0D, 8'h00, 8'h00, 8'h04, 1));
    tbl.push_back(mk(0, 8'h0D, 8'hF0,  1, 8'h0D, 8'h00, 8'h00, 8'h04, 1));
    tbl.push_back(mk(0, 8'h0D, 8'h04,  1, 8'h0D, 8'h00, 8'h00, 8'h00, 0));
    // reset at cnt=10 of a ch1 rise: no pulse, full latency after release
    tbl.push_back(mk(0, 8'h0F, 8'h00, 12, 8'h0D, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 8'h0F, 8'h00,  1, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h0F, 8'h00, 17, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 8'h0F, 8'h00,  1, 8'h0F, 8'h0F, 8'h00, 8'h0F, 1));
    tbl.push_back(mk(0, 8'h0F, 8'h00,  1, 8'h0F, 8'h00, 8'h00, 8'h0F, 1));

    #2;
    for (int v = 0; v < tbl.size(); v++) begin
      rst = tbl[v].rst; raw = tbl[v].raw; ack = tbl[v].ack;
      step(tbl[v].steps);
      check($sformatf("vec%0d_level", v), level, tbl[v].level);
      check($sformatf("vec%0d_rise",  v), rise,  tbl[v].rise);
      check($sformatf("vec%0d_fall",  v), fall,  tbl[v].fall);
      check($sformatf("vec%0d_pend",  v), pend,  tbl[v].pend);
      check($sformatf("vec%0d_chg",   v), {7'd0, chg}, {7'd0, tbl[v].chg});
    end
    ack = 8'h00;

    // falling-edge-only instance: ch5 0->1->0
    rise5_cnt = 0; fall5_cnt = 0;
    check("m2_idle_level", level1, 8'h00);
    raw1 = 8'h20;
    step(17);
    check("m2_rise_early", level1, 8'h00);
    step(1);
    check("m2_rise_level", level1, 8'h20);
    check("m2_rise_pulse", rise1, 8'h20);
    check("m2_rise_nopend", pend1, 8'h00);
    check("m2_rise_nochg", {7'd0, chg1}, 8'h00);
    step(3);
    raw1 = 8'h00;
    step(17);
    check("m2_fall_early", pend1, 8'h00);
    step(1);
    check("m2_fall_level", level1, 8'h00);
    check("m2_fall_pulse", fall1, 8'h20);
    check("m2_fall_pend", pend1, 8'h20);
    check("m2_fall_chg", {7'd0, chg1}, 8'h01);
    step(3);
    check("m2_fall_hold", pend1, 8'h20);
    check("m2_rise_count", 8'(rise5_cnt), 8'd1);
    check("m2_fall_count", 8'(fall5_cnt), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
